switching_gen_ctrl: RTL and testbench
=====================================

SWITCHING_GEN_CTRL -- requirements
Module: switching_gen_ctrl

Interface
REQ-001 SHALL have parameter M, default 4: generator register width; matrices are M x M.
REQ-002 SHALL have parameter OUT_W, default 8: bits per output word.
REQ-003 SHALL use one clock and an asynchronous, active-low reset.
REQ-004 SHALL have port clk, input, 1: sole clock, rising edge.
REQ-005 SHALL have port rst_n, input, 1: asynchronous active-low reset.
REQ-006 SHALL have port start, input, 1: begin a configuration load; honoured in IDLE only.
REQ-007 SHALL have port stop, input, 1: abort RUN or LOAD.
REQ-008 SHALL have port cfg_data, input, [0:M-1]: one configuration word.
REQ-009 SHALL have port cfg_valid, input, 1: cfg_data valid.
REQ-010 SHALL have port cfg_ready, output, 1: controller accepts cfg_data.
REQ-011 SHALL have port b_trans_1_mat_set, output, [0:M*M-1]: matrix 1 to generator.
REQ-012 SHALL have port b_trans_2_mat_set, output, [0:M*M-1]: matrix 2 to generator.
REQ-013 SHALL have port b_lfsr_set, output, [0:M-1]: seed to generator.
REQ-014 SHALL have port set, output, 1: one-cycle load strobe to generator.
REQ-015 SHALL have port step, output, 1: generator clock enable; generator advances on each edge with step=1.
REQ-016 SHALL have port gen_bit, input, 1: current generator output bit.
REQ-017 SHALL have port out_data, output, [0:OUT_W-1]: assembled keystream word.
REQ-018 SHALL have port out_valid, output, 1: out_data valid.
REQ-019 SHALL have port out_ready, input, 1: consumer accepts out_data.
REQ-020 SHALL have port busy, output, 1: high whenever state != IDLE.

Function
REQ-021 SHALL implement states IDLE, LOAD, SET, RUN.
REQ-022 SHALL, in IDLE with start=1, move to LOAD and clear the word counter; cfg_ready=0 in IDLE.
REQ-023 SHALL, in LOAD, hold cfg_ready=1 and accept a word on each edge with cfg_valid=1; gaps in cfg_valid are allowed.
REQ-024 SHALL accept exactly 2M+1 words: words 0..M-1 are rows 0..M-1 of matrix 1 (word k to bits [k*M : k*M+M-1], cfg_data[0] to lowest index), words M..2M-1 are matrix 2 rows, and word 2M is the seed.
REQ-025 SHALL move to SET on the edge accepting word 2M; cfg_ready=0 in SET.
REQ-026 SHALL assert set for exactly the one cycle spent in SET, then move to RUN.
REQ-027 SHALL hold the config outputs stable from SET until the next LOAD writes them.
REQ-028 SHALL, in RUN, assert step each cycle unless stalled (REQ-031), and on each edge with step=1 shift gen_bit into the shift register at index 0 first, with earlier bits at lower index.
REQ-029 SHALL, on the edge completing OUT_W bits, transfer the shift register to out_data and set out_valid when the holding register is empty or is being drained on that edge; the bit counter wraps to 0.
REQ-030 SHALL clear out_valid on an edge with out_valid=1 and out_ready=1, unless a new word loads on the same edge, in which case out_valid stays 1 with the new data.
REQ-031 SHALL stall (step=0) when the shift register holds OUT_W bits and the transfer cannot occur; step resumes the cycle after out_ready=1 is sampled.
REQ-032 SHALL, on stop=1 in LOAD or RUN, go to IDLE on that edge: step=0 from the next cycle, partial shift bits discarded, pending out_valid word retained until accepted; in LOAD, partially loaded config is retained but set is not issued.
REQ-033 SHALL give stop priority over completion of the last LOAD word on the same edge.
REQ-034 SHALL ignore start outside IDLE.

Reset
REQ-035 SHALL, while rst_n=0, immediately force state IDLE, all counters 0, shift and holding registers 0, and outputs cfg_ready, set, step, out_valid, busy to 0, with out_data, b_trans_1_mat_set, b_trans_2_mat_set and b_lfsr_set set to 0.
REQ-036 SHALL, after rst_n rises mid-operation, behave as from power-up; no set pulse is issued.

Verification
REQ-037 SHALL check this: rst_n low during RUN produces all outputs 0 asynchronously (before the next edge) and busy=0.
REQ-038 SHALL check this: with M=4, start, then 9 words with cfg_valid gaps (seed 4'b1000) produce set high for exactly one cycle after word 9, b_lfsr_set=1000, and matrices matching row order.
REQ-039 SHALL check this: with OUT_W=4, gen_bit 1,0,1,1 on four steps produces out_data=1011 and out_valid=1 the cycle after the 4th step.
REQ-040 SHALL check this: with out_ready=0, step drops after 2*OUT_W steps; raising out_ready makes step return next cycle with no bit lost or duplicated.
REQ-041 SHALL check this: stop after 2 bits of a word gives step=0 the next cycle, IDLE, the pending word still valid, and a following word built from fresh bits only.
REQ-042 SHALL check this: start during RUN and cfg_valid in IDLE are both ignored, with state and outputs unchanged.

Source files
------------

// File: rtl/switching_gen_ctrl.sv
// Switching-generator controller: loads two MxM transition matrices and a
// seed from a word stream, strobes them into the generator, then clocks the
// generator and packs its output bits into OUT_W-bit words behind a
// valid/ready holding register.
module switching_gen_ctrl #(
  parameter int M     = 4,
  parameter int OUT_W = 8
) (
  input  logic             clk,
  input  logic             rst_n,
  input  logic             start,
  input  logic             stop,
  input  logic [0:M-1]     cfg_data,
  input  logic             cfg_valid,
  output logic             cfg_ready,
  output logic [0:M*M-1]   b_trans_1_mat_set,
  output logic [0:M*M-1]   b_trans_2_mat_set,
  output logic [0:M-1]     b_lfsr_set,
  output logic             set,
  output logic             step,
  input  logic             gen_bit,
  output logic [0:OUT_W-1] out_data,
  output logic             out_valid,
  input  logic             out_ready,
  output logic             busy
);

  localparam int CW = $clog2(2*M+1);
  localparam int BW = (OUT_W > 1) ? $clog2(OUT_W) : 1;

  typedef enum logic [1:0] {IDLE, LOAD, SET, RUN} state_e;

  state_e           state_q;
  logic [CW-1:0]    wcnt_q;
  logic [BW-1:0]    bcnt_q;
  logic [0:OUT_W-1] sr_q, sr_d;
  logic             full_q;
  logic [0:M*M-1]   mat1_q, mat1_d, mat2_q, mat2_d;
  logic [0:M-1]     seed_q, seed_d;
  logic [0:OUT_W-1] od_q;
  logic             ov_q;

  logic last_bit, hold_free, xfer_new, xfer_sr;

  // Generator runs whenever in RUN and no completed word is stuck in the shifter.
  assign step      = (state_q == RUN) && !full_q;
  assign last_bit  = step && (bcnt_q == BW'(OUT_W-1));
  assign hold_free = !ov_q || out_ready;
  assign xfer_new  = (state_q == RUN) && !stop && last_bit && hold_free;
  assign xfer_sr   = (state_q == RUN) && !stop && full_q && hold_free;

  assign cfg_ready         = (state_q == LOAD);
  assign set               = (state_q == SET);
  assign busy              = (state_q != IDLE);
  assign out_data          = od_q;
  assign out_valid         = ov_q;
  assign b_trans_1_mat_set = mat1_q;
  assign b_trans_2_mat_set = mat2_q;
  assign b_lfsr_set        = seed_q;

  // Next shifter contents and config-word placement selected by the counters.
  always_comb begin
    sr_d   = sr_q;
    mat1_d = mat1_q;
    mat2_d = mat2_q;
    seed_d = seed_q;
    for (int i = 0; i < OUT_W; i++)
      if (bcnt_q == BW'(i)) sr_d[i] = gen_bit;
    for (int k = 0; k < M; k++) begin
      if (wcnt_q == CW'(k))     mat1_d[k*M +: M] = cfg_data;
      if (wcnt_q == CW'(M + k)) mat2_d[k*M +: M] = cfg_data;
    end
    if (wcnt_q == CW'(2*M)) seed_d = cfg_data;
  end

  // Controller FSM, config registers, bit packer and output holding register.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state_q <= IDLE;
      wcnt_q  <= '0;
      bcnt_q  <= '0;
      sr_q    <= '0;
      full_q  <= 1'b0;
      mat1_q  <= '0;
      mat2_q  <= '0;
      seed_q  <= '0;
      od_q    <= '0;
      ov_q    <= 1'b0;
    end else begin
      // holding register keeps working in every state so a pending word drains
      if (xfer_sr) begin
        od_q   <= sr_q;
        ov_q   <= 1'b1;
        full_q <= 1'b0;
      end else if (xfer_new) begin
        od_q <= sr_d;
        ov_q <= 1'b1;
      end else if (ov_q && out_ready) begin
        ov_q <= 1'b0;
      end

      case (state_q)
        IDLE: if (start) begin
          state_q <= LOAD;
          wcnt_q  <= '0;
        end
        LOAD: begin
          if (cfg_valid) begin
            mat1_q <= mat1_d;
            mat2_q <= mat2_d;
            seed_q <= seed_d;
            wcnt_q <= wcnt_q + 1'b1;
          end
          // stop wins over completing the last word: no set pulse
          if (stop)                                        state_q <= IDLE;
          else if (cfg_valid && (wcnt_q == CW'(2*M)))      state_q <= SET;
        end
        SET: begin
          state_q <= RUN;
          bcnt_q  <= '0;
        end
        RUN: begin
          if (stop) begin
            state_q <= IDLE;
            bcnt_q  <= '0;
            sr_q    <= '0;
            full_q  <= 1'b0;
          end else if (step) begin
            sr_q   <= sr_d;
            bcnt_q <= last_bit ? '0 : bcnt_q + 1'b1;
            if (last_bit && !hold_free) full_q <= 1'b1;
          end
        end
        default: state_q <= IDLE;
      endcase
    end
  end

endmodule

// File: tb/tb_switching_gen_ctrl.sv
// Directed bench for switching_gen_ctrl (M=4, OUT_W=4): the bench plays the
// generator, builds expected words from the bits it hands out, and checks
// each accepted output word against a scoreboard queue.
module tb_switching_gen_ctrl;
  localparam int M  = 4;
  localparam int OW = 4;

  logic            clk = 1'b0, rst_n = 1'b0, start = 1'b0, stop = 1'b0;
  logic            cfg_valid = 1'b0, gen_bit = 1'b0, out_ready = 1'b0;
  logic [0:M-1]    cfg_data = '0;
  logic            cfg_ready, set, step, out_valid, busy;
  logic [0:M*M-1]  m1, m2;
  logic [0:M-1]    seed;
  logic [0:OW-1]   out_data;

  int total = 0, bad = 0, nsteps = 0;
  logic [0:OW-1] exp_q[$];
  logic          part[$];
  logic          src[$];
  logic [0:M-1]  wA [0:2*M];
  logic [0:M-1]  wB [0:2*M];

  switching_gen_ctrl #(.M(M), .OUT_W(OW)) dut (
    .clk(clk), .rst_n(rst_n), .start(start), .stop(stop),
    .cfg_data(cfg_data), .cfg_valid(cfg_valid), .cfg_ready(cfg_ready),
    .b_trans_1_mat_set(m1), .b_trans_2_mat_set(m2), .b_lfsr_set(seed),
    .set(set), .step(step), .gen_bit(gen_bit),
    .out_data(out_data), .out_valid(out_valid), .out_ready(out_ready), .busy(busy)
  );

  always #5 clk = ~clk;

  initial begin
    #100000;
    $display("FAIL timeout: observed=running required=finished");
    $fatal(1, "timeout");
  end

  task automatic chk(input string tag, input logic [63:0] obs, input logic [63:0] exp);
    total++;
    assert (obs === exp) else begin
      bad++;
      $error("FAIL %s: observed=%0h expected=%0h", tag, obs, exp);
    end
  endtask

  function automatic logic next_bit();
    if (src.size() > 0) return src.pop_front();
    return 1'($urandom_range(0, 1));
  endfunction

  // One clock: score any accepted word, then model the generator advance.
  task automatic tick();
    logic stepped, stopped;
    logic [0:OW-1] w;
    stepped = step;
    stopped = stop;
    if (out_valid && out_ready) begin
      chk("sb_avail", 64'(exp_q.size() > 0), 64'(1));
      if (exp_q.size() > 0) chk("sb_word", 64'(out_data), 64'(exp_q.pop_front()));
    end
    @(posedge clk); #1;
    if (stepped) begin
      nsteps++;
      part.push_back(gen_bit);
      if (part.size() == OW) begin
        for (int i = 0; i < OW; i++) w[i] = part[i];
        exp_q.push_back(w);
        part.delete();
      end
      gen_bit = next_bit();
    end
    if (stopped) part.delete();
  endtask

  task automatic load_cfg(input logic [0:M-1] w [0:2*M]);
    start = 1'b1; tick(); start = 1'b0;
    chk("load_ready", 64'(cfg_ready), 64'(1));
    for (int k = 0; k <= 2*M; k++) begin
      if (k % 2 == 1) begin cfg_valid = 1'b0; tick(); end
      cfg_valid = 1'b1; cfg_data = w[k]; tick(); cfg_valid = 1'b0;
      if (k < 2*M) chk("set_early", 64'(set), 64'(0));
    end
    chk("set_pulse", 64'(set), 64'(1));
    chk("set_ready", 64'(cfg_ready), 64'(0));
    chk("set_busy", 64'(busy), 64'(1));
    tick();
    chk("set_once", 64'(set), 64'(0));
    chk("run_step", 64'(step), 64'(1));
  endtask

  initial begin
    int g;
    wA = '{4'b1000, 4'b0100, 4'b0010, 4'b0001, 4'b1100, 4'b0110, 4'b0011, 4'b1001, 4'b1000};
    wB = '{4'b1010, 4'b0101, 4'b1111, 4'b0000, 4'b0001, 4'b0011, 4'b0111, 4'b1110, 4'b0110};

    // reset state
    #12;
    chk("rst_ready", 64'(cfg_ready), 64'(0));
    chk("rst_set",   64'(set),       64'(0));
    chk("rst_step",  64'(step),      64'(0));
    chk("rst_ovld",  64'(out_valid), 64'(0));
    chk("rst_busy",  64'(busy),      64'(0));
    chk("rst_m1",    64'(m1),        64'(0));
    rst_n = 1'b1;
    @(posedge clk); #1;

    // config load with gaps, directed first bits 1,0,1,1
    src = '{1'b1, 1'b0, 1'b1, 1'b1};
    gen_bit = next_bit();
    out_ready = 1'b0;
    load_cfg(wA);
    chk("m1_A",   64'(m1),   64'(16'b1000010000100001));
    chk("m2_A",   64'(m2),   64'(16'b1100011000111001));
    chk("seed_A", 64'(seed), 64'(4'b1000));

    // first word assembled after four steps
    g = 0; nsteps = 0;
    while (nsteps < 4 && g < 20) begin tick(); g++; end
    chk("w1_valid", 64'(out_valid), 64'(1));
    chk("w1_data",  64'(out_data),  64'(4'b1011));

    // back-pressure: stall after two words' worth of steps
    g = 0;
    while (step && g < 40) begin tick(); g++; end
    chk("stall_steps", 64'(nsteps), 64'(2*OW));
    tick(); tick();
    chk("stall_hold", 64'(step), 64'(0));
    chk("stall_data", 64'(out_data), 64'(4'b1011));
    out_ready = 1'b1;
    tick();
    chk("resume_step", 64'(step), 64'(1));
    chk("resume_vld",  64'(out_valid), 64'(1));
    for (int i = 0; i < 10; i++) tick();

    // stop with a pending word and two partial bits
    out_ready = 1'b0;
    g = 0;
    while (!(out_valid && part.size() == 2) && g < 40) begin tick(); g++; end
    chk("pre_stop_part", 64'(part.size()), 64'(2));
    stop = 1'b1; tick(); stop = 1'b0;
    chk("stop_step", 64'(step), 64'(0));
    chk("stop_busy", 64'(busy), 64'(0));
    chk("stop_vld",  64'(out_valid), 64'(1));
    chk("stop_pend", 64'(exp_q.size()), 64'(1));
    chk("stop_data", 64'(out_data), 64'(exp_q[0]));
    tick();
    chk("idle_step", 64'(step), 64'(0));

    // cfg_valid in IDLE is ignored
    cfg_valid = 1'b1; cfg_data = 4'b1111; tick(); cfg_valid = 1'b0;
    chk("idle_ready", 64'(cfg_ready), 64'(0));
    chk("idle_busy",  64'(busy), 64'(0));
    chk("idle_m1",    64'(m1),   64'(16'b1000010000100001));
    chk("idle_seed",  64'(seed), 64'(4'b1000));

    // reload, then drain old pending word followed by fresh words
    load_cfg(wB);
    chk("m1_B",   64'(m1),   64'(16'b1010010111110000));
    chk("m2_B",   64'(m2),   64'(16'b0001001101111110));
    chk("seed_B", 64'(seed), 64'(4'b0110));
    out_ready = 1'b1;
    for (int i = 0; i < 14; i++) tick();

    // start during RUN is ignored
    start = 1'b1; tick(); start = 1'b0;
    chk("run_start_busy", 64'(busy), 64'(1));
    chk("run_start_set",  64'(set),  64'(0));
    chk("run_start_rdy",  64'(cfg_ready), 64'(0));
    chk("run_start_step", 64'(step), 64'(1));
    tick();
    chk("run_start_set2", 64'(set), 64'(0));

    // asynchronous reset mid-RUN
    rst_n = 1'b0;
    #2;
    chk("arst_step", 64'(step),      64'(0));
    chk("arst_busy", 64'(busy),      64'(0));
    chk("arst_ovld", 64'(out_valid), 64'(0));
    chk("arst_data", 64'(out_data),  64'(0));
    chk("arst_m2",   64'(m2),        64'(0));
    chk("arst_seed", 64'(seed),      64'(0));
    exp_q.delete(); part.delete();
    @(posedge clk); #1;
    rst_n = 1'b1;
    for (int i = 0; i < 3; i++) begin
      tick();
      chk("post_rst_set",  64'(set),  64'(0));
      chk("post_rst_busy", 64'(busy), 64'(0));
    end

    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end
endmodule
